// File: rtl/filter_seq_ctrl.sv
// filter_seq_ctrl: sequencer for one filter_p_m channel (I or Q half).
//   clk, rst           core clock, synchronous active-high reset
//   en                 run enable
//   cclk_div, lo_div   half-period minus 1 for cclk / lo (latched on IDLE->RUN)
//   win_len            decisions per window, 0 treated as 1 (latched on IDLE->RUN)
//   high_buf, phi1b_dig  asynchronous comparator output and filter event clock
//   cclk, div2, lo, fb1  filter drive signals
//   cnt_data, cnt_valid, cnt_ready  windowed ones-count, valid/ready handshake
//   overflow           sticky: a window result was dropped
module filter_seq_ctrl #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cclk_div,
  input  logic [DIV_W-1:0] lo_div,
  input  logic [CNT_W-1:0] win_len,
  input  logic             high_buf,
  input  logic             phi1b_dig,
  output logic             cclk,
  output logic             div2,
  output logic             lo,
  output logic             fb1,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] cclk_div_q, lo_div_q, cclk_cnt, lo_cnt;
  logic [CNT_W-1:0] win_len_q, samp_cnt, ones_cnt;
  logic             hb_s1, hb_s2, ph_s1, ph_s2, ph_s3;
  logic             cap_v, cap_d;

  logic             cclk_term, lo_term, detect, win_done;
  logic [CNT_W-1:0] samp_nxt, ones_nxt;

  always_comb begin
    cclk_term = (cclk_cnt == cclk_div_q);
    lo_term   = (lo_cnt == lo_div_q);
    detect    = ph_s2 & ~ph_s3;
    samp_nxt  = samp_cnt + CNT_W'(1);
    ones_nxt  = ones_cnt + CNT_W'(cap_d);
    win_done  = (samp_nxt == win_len_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cclk_div_q <= '0;
      lo_div_q   <= '0;
      win_len_q  <= '0;
      cclk_cnt   <= '0;
      lo_cnt     <= '0;
      samp_cnt   <= '0;
      ones_cnt   <= '0;
      hb_s1      <= 1'b0;
      hb_s2      <= 1'b0;
      ph_s1      <= 1'b0;
      ph_s2      <= 1'b0;
      ph_s3      <= 1'b0;
      cap_v      <= 1'b0;
      cap_d      <= 1'b0;
      cclk       <= 1'b0;
      div2       <= 1'b0;
      lo         <= 1'b0;
      fb1        <= 1'b0;
      cnt_data   <= '0;
      cnt_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      hb_s1 <= high_buf;
      hb_s2 <= hb_s1;
      ph_s1 <= phi1b_dig;
      ph_s2 <= ph_s1;
      ph_s3 <= ph_s2;
      cap_v <= detect && (state != IDLE);
      cap_d <= hb_s2;

      if (cnt_valid && cnt_ready)
        cnt_valid <= 1'b0;

      // Decision applied one cycle after capture; an emit overrides the
      // transfer-clear above, and is dropped only when the slot stays occupied.
      if (cap_v && (state != IDLE)) begin
        fb1 <= cap_d;
        if (win_done) begin
          samp_cnt <= '0;
          ones_cnt <= '0;
          if (!cnt_valid || cnt_ready) begin
            cnt_data  <= ones_nxt;
            cnt_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          samp_cnt <= samp_nxt;
          ones_cnt <= ones_nxt;
        end
      end

      case (state)
        IDLE: begin
          if (en) begin
            state      <= RUN;
            cclk_div_q <= cclk_div;
            lo_div_q   <= lo_div;
            win_len_q  <= (win_len == '0) ? CNT_W'(1) : win_len;
            cclk_cnt   <= '0;
            lo_cnt     <= '0;
            samp_cnt   <= '0;
            ones_cnt   <= '0;
            overflow   <= 1'b0;
          end
        end
        RUN, STOP: begin
          // Leave only at the end of a full low phase so cclk never runts.
          if ((state == STOP) && !cclk && cclk_term) begin
            state    <= IDLE;
            cclk     <= 1'b0;
            div2     <= 1'b0;
            lo       <= 1'b0;
            cclk_cnt <= '0;
            lo_cnt   <= '0;
            samp_cnt <= '0;
            ones_cnt <= '0;
          end else begin
            if ((state == RUN) && !en)
              state <= STOP;
            cclk_cnt <= cclk_term ? '0 : cclk_cnt + DIV_W'(1);
            lo_cnt   <= lo_term ? '0 : lo_cnt + DIV_W'(1);
            if (cclk_term) begin
              cclk <= ~cclk;
              if (!cclk)
                div2 <= ~div2;
            end
            if (lo_term)
              lo <= ~lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_seq_ctrl.sv
module tb_filter_seq_ctrl;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, en, high_buf, phi1b_dig, cnt_ready;
  logic [DIV_W-1:0] cclk_div, lo_div;
  logic [CNT_W-1:0] win_len;
  logic             cclk, div2, lo, fb1, cnt_valid, overflow;
  logic [CNT_W-1:0] cnt_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  filter_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cclk_div(cclk_div), .lo_div(lo_div),
    .win_len(win_len), .high_buf(high_buf), .phi1b_dig(phi1b_dig),
    .cclk(cclk), .div2(div2), .lo(lo), .fb1(fb1), .cnt_data(cnt_data),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned t0;
    bit          d;
    bit          live;
  } cap_t;

  cap_t        capq[$];
  bit          m_init = 0, m_active = 0, m_stop = 0, prev_p = 0;
  int unsigned ecnt = 0, t = 0, md = 1, ml = 1, mw = 1, m_samp = 0, m_ones = 0;
  bit          m_cclk = 0, m_div2 = 0, m_lo = 0, m_fb = 0, m_valid = 0, m_ovf = 0;
  int unsigned m_data = 0;

  initial begin
    bit ab, xfer, emit;
    int unsigned res, n;
    forever begin
      @(posedge clk);
      ecnt++;
      m_init = 1;
      if (rst) begin
        m_active = 0; m_stop = 0; prev_p = 0; t = 0;
        m_samp = 0; m_ones = 0; m_fb = 0; m_valid = 0; m_ovf = 0; m_data = 0;
        capq.delete();
      end else begin
        ab = m_active;
        xfer = m_valid && cnt_ready;
        emit = 0;
        res = 0;
        // pin rise seen at edge t0: capture at t0+2, applied at t0+3
        foreach (capq[i]) begin
          if (ecnt == capq[i].t0 + 2 && !ab) capq[i].live = 0;
          if (ecnt == capq[i].t0 + 3 && capq[i].live && ab) begin
            m_fb = capq[i].d;
            m_samp++;
            m_ones += int'(capq[i].d);
            if (m_samp == mw) begin
              emit = 1; res = m_ones; m_samp = 0; m_ones = 0;
            end
          end
        end
        while (capq.size() > 0 && ecnt >= capq[0].t0 + 3) void'(capq.pop_front());
        if (phi1b_dig && !prev_p) capq.push_back('{ecnt, high_buf, 1'b1});
        prev_p = phi1b_dig;

        if (emit) begin
          if (!m_valid || cnt_ready) begin m_data = res; m_valid = 1; end
          else m_ovf = 1;
        end else if (xfer) begin
          m_valid = 0;
        end

        if (!m_active) begin
          if (en) begin
            m_active = 1; m_stop = 0; t = 0;
            md = int'(cclk_div) + 1; ml = int'(lo_div) + 1;
            mw = (win_len == 0) ? 1 : int'(win_len);
            m_samp = 0; m_ones = 0; m_ovf = 0;
          end
        end else if (m_stop && ((t / md) % 2 == 0) && (t % md == md - 1)) begin
          m_active = 0; m_samp = 0; m_ones = 0;
        end else begin
          t++;
          if (!en) m_stop = 1;
        end
      end
      if (m_active) begin
        n = t / md;
        m_cclk = (n % 2) == 1;
        m_div2 = (((n + 1) / 2) % 2) == 1;
        m_lo   = ((t / ml) % 2) == 1;
      end else begin
        m_cclk = 0; m_div2 = 0; m_lo = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      check("cclk", 32'(cclk), 32'(m_cclk));
      check("div2", 32'(div2), 32'(m_div2));
      check("lo", 32'(lo), 32'(m_lo));
      check("fb1", 32'(fb1), 32'(m_fb));
      check("cnt_valid", 32'(cnt_valid), 32'(m_valid));
      check("cnt_data", 32'(cnt_data), m_data);
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit hb, input bit late_rdy);
    @(negedge clk); phi1b_dig = 1'b0; high_buf = hb;
    @(negedge clk);
    @(negedge clk); phi1b_dig = 1'b1;
    repeat (3) @(posedge clk);
    if (late_rdy) begin @(negedge clk); cnt_ready = 1'b1; end
    @(posedge clk); #1;
    check("fb1_latency", 32'(fb1), 32'(hb));
  endtask

  task automatic phi_low();
    @(negedge clk); phi1b_dig = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk); en = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic go_run();
    @(negedge clk); en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; en = 1'b1; cclk_div = 8'd3; lo_div = 8'd1; win_len = 16'd4;
    cnt_ready = 1'b1; high_buf = 1'b0; phi1b_dig = 1'b0;

    // reset with en=1, then cclk_div=3
    repeat (3) @(negedge clk);
    check("rst_cclk", 32'(cclk), 0);
    check("rst_cnt_valid", 32'(cnt_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_fb1", 32'(fb1), 0);
    rst = 1'b0;
    @(posedge clk);
    repeat (3) @(posedge clk); #1;
    check("cclk_before_first_rise", 32'(cclk), 0);
    @(posedge clk); #1;
    check("cclk_first_rise", 32'(cclk), 1);
    check("div2_first_rise", 32'(div2), 1);
    repeat (4) @(posedge clk); #1;
    check("cclk_fall_t8", 32'(cclk), 0);
    repeat (4) @(posedge clk); #1;
    check("cclk_rise_t12", 32'(cclk), 1);
    check("div2_t12", 32'(div2), 0);

    // lo_div=1, cclk_div=4; stop while cclk high
    go_idle();
    cclk_div = 8'd4; lo_div = 8'd1;
    @(negedge clk); en = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (cclk) seen = 1;
    end
    check("cclk_rise_seen", 32'(seen), 1);
    @(negedge clk); en = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("cclk_high_phase", 32'(cclk), 1);
    @(posedge clk); #1;
    check("cclk_fall_on_stop", 32'(cclk), 0);
    repeat (5) @(posedge clk); #1;
    check("idle_lo", 32'(lo), 0);
    check("idle_cclk", 32'(cclk), 0);
    repeat (4) @(negedge clk);

    // window of 4, pattern 1,0,1,1
    cclk_div = 8'd3; lo_div = 8'd1; win_len = 16'd4; cnt_ready = 1'b1;
    go_run();
    pulse(1, 0); pulse(0, 0); pulse(1, 0); pulse(1, 0);
    check("win4_valid", 32'(cnt_valid), 1);
    check("win4_data", 32'(cnt_data), 3);
    @(posedge clk); #1;
    check("win4_valid_drop", 32'(cnt_valid), 0);
    phi_low();

    // win_len=0 behaves as 1
    go_idle();
    win_len = 16'd0;
    go_run();
    pulse(0, 0);
    check("w0_valid_a", 32'(cnt_valid), 1); check("w0_data_a", 32'(cnt_data), 0);
    pulse(1, 0);
    check("w0_valid_b", 32'(cnt_valid), 1); check("w0_data_b", 32'(cnt_data), 1);
    pulse(1, 0);
    check("w0_data_c", 32'(cnt_data), 1);
    pulse(0, 0);
    check("w0_data_d", 32'(cnt_data), 0);
    phi_low();

    // overflow: win_len=2, consumer stalled for 3 windows
    go_idle();
    win_len = 16'd2; cnt_ready = 1'b0;
    go_run();
    pulse(1, 0); pulse(1, 0); pulse(0, 0); pulse(1, 0); pulse(1, 0); pulse(0, 0);
    check("ovf_data_held", 32'(cnt_data), 2);
    check("ovf_valid", 32'(cnt_valid), 1);
    check("ovf_set", 32'(overflow), 1);
    phi_low();
    cnt_ready = 1'b1;
    @(posedge clk); #1;
    check("ovf_xfer_valid", 32'(cnt_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);
    go_idle();
    check("ovf_sticky_idle", 32'(overflow), 1);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    check("ovf_clear_on_run", 32'(overflow), 0);

    // emit coinciding with acceptance
    go_idle();
    win_len = 16'd1; cnt_ready = 1'b0;
    go_run();
    pulse(1, 0);
    check("coinc_first", 32'(cnt_data), 1);
    pulse(0, 1);
    check("coinc_data", 32'(cnt_data), 0);
    check("coinc_valid", 32'(cnt_valid), 1);
    check("coinc_ovf", 32'(overflow), 0);
    phi_low();

    // reset mid-window
    go_idle();
    win_len = 16'd4;
    go_run();
    pulse(1, 0); pulse(1, 0);
    phi_low();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_valid", 32'(cnt_valid), 0);
    check("midrst_fb1", 32'(fb1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse(1, 0); pulse(1, 0);
    check("midrst_no_emit", 32'(cnt_valid), 0);
    pulse(1, 0); pulse(0, 0);
    check("midrst_emit_valid", 32'(cnt_valid), 1);
    check("midrst_emit_data", 32'(cnt_data), 3);
    phi_low();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
